// File: rtl/snake_body_tracker_if.sv
// Bundles the game-side control inputs and the per-part coordinate outputs of the snake body tracker.
// The controller/bench side uses master; the tracker itself uses slave.
interface snake_body_tracker_if #(
    parameter int N_PARTS = 10,
    parameter int COORD_W = 6
);
    logic                         game_run;
    logic                         move_tick;
    logic                         dir_valid;
    logic [1:0]                   dir_in;
    logic [N_PARTS-1:0]           active_mask;
    logic [N_PARTS*COORD_W-1:0]   part_x_flat;
    logic [N_PARTS*COORD_W-1:0]   part_y_flat;
    logic [COORD_W-1:0]           head_x;
    logic [COORD_W-1:0]           head_y;
    logic [1:0]                   cur_dir;
    logic                         self_hit;
    logic                         running;

    modport master (
        output game_run, move_tick, dir_valid, dir_in, active_mask,
        input  part_x_flat, part_y_flat, head_x, head_y, cur_dir, self_hit, running
    );

    modport slave (
        input  game_run, move_tick, dir_valid, dir_in, active_mask,
        output part_x_flat, part_y_flat, head_x, head_y, cur_dir, self_hit, running
    );
endinterface

// File: rtl/snake_body_tracker.sv
// Holds the grid coordinates of every snake part, advances them one cell per move_tick
// with wrap-around, and flags a sticky self-collision against the active body parts.
module snake_body_tracker #(
    parameter int N_PARTS = 10,
    parameter int COORD_W = 6,
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int START_X = 20,
    parameter int START_Y = 15
) (
    input  logic                clk,
    input  logic                rst,
    snake_body_tracker_if.slave sb
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT} state_e;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;
    localparam int         EXT_W     = COORD_W + 1;

    function automatic logic [COORD_W-1:0] start_x_of(input int idx);
        return COORD_W'(START_X - idx);
    endfunction

    state_e             state_q, state_d;
    logic [COORD_W-1:0] px_q [N_PARTS];
    logic [COORD_W-1:0] px_d [N_PARTS];
    logic [COORD_W-1:0] py_q [N_PARTS];
    logic [COORD_W-1:0] py_d [N_PARTS];
    logic [1:0]         cur_dir_q, cur_dir_d;
    logic [1:0]         next_dir_q, next_dir_d;
    logic               self_hit_q, self_hit_d;
    logic               running_q, running_d;

    logic               dir_accept;
    logic [EXT_W-1:0]   x_ext, y_ext;
    logic [COORD_W-1:0] new_x, new_y;
    logic               hit;

    // A turn is dropped when it would reverse onto the neck (codes differ only in bit 1).
    always_comb begin
        dir_accept = sb.dir_valid && ((sb.dir_in ^ cur_dir_q) != 2'b10);
        next_dir_d = dir_accept ? sb.dir_in : next_dir_q;
    end

    // Underflow shows up as the extra MSB; overflow as equality with the grid size.
    always_comb begin
        x_ext = {1'b0, px_q[0]};
        y_ext = {1'b0, py_q[0]};
        case (next_dir_d)
            DIR_UP:    y_ext = y_ext - EXT_W'(1);
            DIR_RIGHT: x_ext = x_ext + EXT_W'(1);
            DIR_DOWN:  y_ext = y_ext + EXT_W'(1);
            DIR_LEFT:  x_ext = x_ext - EXT_W'(1);
            default:   ;
        endcase

        if (x_ext[EXT_W-1])
            new_x = COORD_W'(GRID_W - 1);
        else if (x_ext == EXT_W'(GRID_W))
            new_x = '0;
        else
            new_x = x_ext[COORD_W-1:0];

        if (y_ext[EXT_W-1])
            new_y = COORD_W'(GRID_H - 1);
        else if (y_ext == EXT_W'(GRID_H))
            new_y = '0;
        else
            new_y = y_ext[COORD_W-1:0];
    end

    // Old part i-1 is where part i lands after the shift, so this checks the post-move body.
    always_comb begin
        hit = 1'b0;
        for (int i = 2; i < N_PARTS; i++) begin
            if (sb.active_mask[i] && new_x == px_q[i-1] && new_y == py_q[i-1])
                hit = 1'b1;
        end
    end

    // NOTE: every _d signal takes its _q value first so no path through this block infers a latch.
    always_comb begin
        state_d    = state_q;
        px_d       = px_q;
        py_d       = py_q;
        cur_dir_d  = cur_dir_q;
        self_hit_d = self_hit_q;

        case (state_q)
            S_IDLE: begin
                if (sb.game_run)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (!sb.game_run) begin
                    state_d = S_IDLE;
                end else if (sb.move_tick) begin
                    for (int i = 1; i < N_PARTS; i++) begin
                        px_d[i] = px_q[i-1];
                        py_d[i] = py_q[i-1];
                    end
                    px_d[0]   = new_x;
                    py_d[0]   = new_y;
                    cur_dir_d = next_dir_d;
                    if (hit) begin
                        state_d    = S_HIT;
                        self_hit_d = 1'b1;
                    end
                end
            end
            S_HIT: begin
                if (!sb.game_run) begin
                    state_d    = S_IDLE;
                    self_hit_d = 1'b0;
                    cur_dir_d  = DIR_RIGHT;
                    for (int i = 0; i < N_PARTS; i++) begin
                        px_d[i] = start_x_of(i);
                        py_d[i] = COORD_W'(START_Y);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        running_d = (state_d == S_RUN);
    end

    // NOTE: non-blocking assignments here so every register samples the pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cur_dir_q  <= DIR_RIGHT;
            next_dir_q <= DIR_RIGHT;
            self_hit_q <= 1'b0;
            running_q  <= 1'b0;
            // NOTE: the coordinate array is reset too; the snake must start in a known line.
            for (int i = 0; i < N_PARTS; i++) begin
                px_q[i] <= start_x_of(i);
                py_q[i] <= COORD_W'(START_Y);
            end
        end else begin
            state_q    <= state_d;
            cur_dir_q  <= cur_dir_d;
            self_hit_q <= self_hit_d;
            running_q  <= running_d;
            px_q       <= px_d;
            py_q       <= py_d;
            if (state_q == S_HIT && !sb.game_run)
                next_dir_q <= DIR_RIGHT;
            else
                next_dir_q <= next_dir_d;
        end
    end

    always_comb begin
        sb.part_x_flat = '0;
        sb.part_y_flat = '0;
        for (int i = 0; i < N_PARTS; i++) begin
            sb.part_x_flat[i*COORD_W +: COORD_W] = px_q[i];
            sb.part_y_flat[i*COORD_W +: COORD_W] = py_q[i];
        end
    end

    assign sb.head_x   = px_q[0];
    assign sb.head_y   = py_q[0];
    assign sb.cur_dir  = cur_dir_q;
    assign sb.self_hit = self_hit_q;
    assign sb.running  = running_q;
endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker: directed scenarios plus randomized play, all compared
// against a list-based model of the snake that uses modulo arithmetic on plain integers.
module tb_snake_body_tracker;
    localparam int N_PARTS = 10;
    localparam int COORD_W = 6;
    localparam int GRID_W  = 40;
    localparam int GRID_H  = 30;
    localparam int START_X = 20;
    localparam int START_Y = 15;
    localparam int FLAT_W  = N_PARTS * COORD_W;

    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HIT  = 2;

    localparam logic [1:0] UP = 2'b00, RIGHT = 2'b01, DOWN = 2'b10, LEFT = 2'b11;
    localparam logic [N_PARTS-1:0] ALL_ON = '1;
    localparam logic [N_PARTS-1:0] TWO_ON = 10'b0000000011;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    snake_body_tracker_if #(.N_PARTS(N_PARTS), .COORD_W(COORD_W)) bus ();

    snake_body_tracker #(
        .N_PARTS(N_PARTS), .COORD_W(COORD_W), .GRID_W(GRID_W), .GRID_H(GRID_H),
        .START_X(START_X), .START_Y(START_Y)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         m_px [N_PARTS];
    int         m_py [N_PARTS];
    logic [1:0] m_cur;
    logic [1:0] m_nxt;
    int         m_mode;
    bit         m_hit;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_PARTS; i++) begin
            m_px[i] = START_X - i;
            m_py[i] = START_Y;
        end
        m_cur  = RIGHT;
        m_nxt  = RIGHT;
        m_mode = MODE_IDLE;
        m_hit  = 1'b0;
    endtask

    task automatic model_step(input bit gr, input bit mt, input bit dv,
                              input logic [1:0] di, input logic [N_PARTS-1:0] m);
        int nx;
        int ny;
        bit hit;
        if (dv && ((di ^ m_cur) != 2'b10))
            m_nxt = di;
        if (m_mode == MODE_IDLE) begin
            if (gr) m_mode = MODE_RUN;
        end else if (m_mode == MODE_HIT) begin
            if (!gr) model_reset();
        end else if (!gr) begin
            m_mode = MODE_IDLE;
        end else if (mt) begin
            nx = m_px[0];
            ny = m_py[0];
            case (m_nxt)
                UP:      ny = (ny + GRID_H - 1) % GRID_H;
                RIGHT:   nx = (nx + 1) % GRID_W;
                DOWN:    ny = (ny + 1) % GRID_H;
                default: nx = (nx + GRID_W - 1) % GRID_W;
            endcase
            for (int i = N_PARTS - 1; i > 0; i--) begin
                m_px[i] = m_px[i-1];
                m_py[i] = m_py[i-1];
            end
            hit = 1'b0;
            for (int i = 2; i < N_PARTS; i++)
                if (m[i] && m_px[i] == nx && m_py[i] == ny) hit = 1'b1;
            m_px[0] = nx;
            m_py[0] = ny;
            m_cur   = m_nxt;
            if (hit) begin
                m_mode = MODE_HIT;
                m_hit  = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [FLAT_W-1:0] ex;
        logic [FLAT_W-1:0] ey;
        for (int i = 0; i < N_PARTS; i++) begin
            ex[i*COORD_W +: COORD_W] = COORD_W'(m_px[i]);
            ey[i*COORD_W +: COORD_W] = COORD_W'(m_py[i]);
        end
        check({tag, ".head_x"},   64'(bus.head_x),      64'(m_px[0]));
        check({tag, ".head_y"},   64'(bus.head_y),      64'(m_py[0]));
        check({tag, ".part_x"},   64'(bus.part_x_flat), 64'(ex));
        check({tag, ".part_y"},   64'(bus.part_y_flat), 64'(ey));
        check({tag, ".cur_dir"},  64'(bus.cur_dir),     64'(m_cur));
        check({tag, ".self_hit"}, 64'(bus.self_hit),    64'(m_hit));
        check({tag, ".running"},  64'(bus.running),     64'(m_mode == MODE_RUN));
    endtask

    task automatic cycle(input string tag, input bit gr, input bit mt, input bit dv,
                         input logic [1:0] di, input logic [N_PARTS-1:0] m);
        @(negedge clk);
        bus.game_run    = gr;
        bus.move_tick   = mt;
        bus.dir_valid   = dv;
        bus.dir_in      = di;
        bus.active_mask = m;
        model_step(gr, mt, dv, di, m);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        bus.game_run  = 1'b0;
        bus.move_tick = 1'b0;
        bus.dir_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic loop_path(input string tag, input logic [N_PARTS-1:0] m);
        cycle({tag, ".go"},   1, 0, 0, RIGHT, m);
        cycle({tag, ".t1"},   1, 1, 0, RIGHT, m);
        cycle({tag, ".t2"},   1, 1, 1, DOWN,  m);
        cycle({tag, ".t3"},   1, 1, 1, LEFT,  m);
        cycle({tag, ".t4"},   1, 1, 1, UP,    m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.game_run    = 1'b0;
        bus.move_tick   = 1'b0;
        bus.dir_valid   = 1'b0;
        bus.dir_in      = 2'b00;
        bus.active_mask = ALL_ON;
        model_reset();
        #12;
        compare_all("reset");
        check("reset.head_x_const", 64'(bus.head_x), 64'd20);
        @(negedge clk);
        rst = 1'b1;

        // Straight run from reset
        cycle("s1.go", 1, 0, 0, RIGHT, ALL_ON);
        for (int k = 0; k < 3; k++) cycle("s1.tick", 1, 1, 0, RIGHT, ALL_ON);
        check("s1.head_x", 64'(bus.head_x), 64'd23);
        check("s1.head_y", 64'(bus.head_y), 64'd15);
        check("s1.part1_x", 64'(bus.part_x_flat[COORD_W +: COORD_W]), 64'd22);
        check("s1.cur_dir", 64'(bus.cur_dir), 64'(RIGHT));
        check("s1.self_hit", 64'(bus.self_hit), 64'd0);

        // Wrap right edge, then wrap top edge
        for (int k = 0; k < 16; k++) cycle("s2.right", 1, 1, 0, RIGHT, ALL_ON);
        check("s2.at_edge_x", 64'(bus.head_x), 64'd39);
        cycle("s2.wrap_x", 1, 1, 0, RIGHT, ALL_ON);
        check("s2.wrap_x_const", 64'(bus.head_x), 64'd0);
        cycle("s2.turn_up", 1, 0, 1, UP, ALL_ON);
        for (int k = 0; k < 15; k++) cycle("s2.up", 1, 1, 0, UP, ALL_ON);
        check("s2.at_top_y", 64'(bus.head_y), 64'd0);
        cycle("s2.wrap_y", 1, 1, 0, UP, ALL_ON);
        check("s2.wrap_y_const", 64'(bus.head_y), 64'd29);

        // Reversal rejected; same-cycle turn applied
        sync_reset();
        cycle("s3.go", 1, 0, 0, RIGHT, ALL_ON);
        cycle("s3.rev", 1, 0, 1, LEFT, ALL_ON);
        cycle("s3.tick", 1, 1, 0, LEFT, ALL_ON);
        check("s3.rev_x", 64'(bus.head_x), 64'd21);
        cycle("s3.same", 1, 1, 1, UP, ALL_ON);
        check("s3.same_y", 64'(bus.head_y), 64'd14);
        check("s3.same_dir", 64'(bus.cur_dir), 64'(UP));

        // Self-collision loop, then restart from HIT
        sync_reset();
        loop_path("s4", ALL_ON);
        check("s4.self_hit", 64'(bus.self_hit), 64'd1);
        check("s4.running", 64'(bus.running), 64'd0);
        cycle("s4.frozen", 1, 1, 0, RIGHT, ALL_ON);
        cycle("s4.frozen", 1, 1, 1, DOWN, ALL_ON);
        check("s4.frozen_x", 64'(bus.head_x), 64'd20);
        cycle("s4.restart", 0, 0, 0, RIGHT, ALL_ON);
        check("s4.restart_p1x", 64'(bus.part_x_flat[COORD_W +: COORD_W]), 64'd19);
        check("s4.restart_hit", 64'(bus.self_hit), 64'd0);

        // Same loop with only the first two parts active
        loop_path("s5", TWO_ON);
        check("s5.self_hit", 64'(bus.self_hit), 64'd0);
        check("s5.running", 64'(bus.running), 64'd1);

        // Asynchronous reset between edges
        cycle("s6.tick", 1, 1, 0, RIGHT, TWO_ON);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("s6.async");
        check("s6.running", 64'(bus.running), 64'd0);
        bus.game_run  = 1'b0;
        bus.move_tick = 1'b0;
        bus.dir_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Randomized play
        for (int k = 0; k < 600; k++) begin
            logic [N_PARTS-1:0] m;
            m = (k % 97 < 60) ? ALL_ON : N_PARTS'($urandom);
            cycle("rand", ($urandom_range(0, 24) != 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), m);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
